// File: rtl/node_sequencer.sv
// node_sequencer: per-node cycle/phase sequencer driving opt, distance and exp-unit command streams.
// Define NODE_SEQ_PAUSE_EN to add a pause input that holds off the next cycle launch.
package replica_pkg;
   localparam int base_num = 2;
   typedef enum logic [1:0] {OR1 = 2'd0, TWO = 2'd1, THR = 2'd2} opt_command_t;
   typedef enum logic [2:0] {KN, KM, KP, LN, LP, LM} dist_sel_t;
   typedef enum logic [1:0] {DNOP, ZERO, MNS, PLS} dist_op_t;
   typedef struct packed {
      dist_sel_t sel;
      dist_op_t  op;
   } distance_command_t;
endpackage

module node_sequencer
   import replica_pkg::*;
#(
   parameter int STAGE_LEN = 20,
   parameter int EXP_TERMS = 15,
   parameter int RUN_W     = 24,
   parameter int BASE_NUM  = replica_pkg::base_num
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run_write,
   input  logic [RUN_W-1:0]  run_times,
   input  logic              stop,
`ifdef NODE_SEQ_PAUSE_EN
   input  logic              pause,
`endif
   output logic              running,
   output logic              cycle_finish,
   output logic              done,
   output logic [RUN_W-1:0]  run_cnt,
   output logic              opt_run,
   output opt_command_t      opt_com,
   output distance_command_t or_distance_com,
   output distance_command_t tw_distance_com,
   output logic              exp_init,
   output logic              exp_run,
   output logic              exp_fin,
   output logic [16:0]       exp_recip
);

   localparam int CYC = 10 * STAGE_LEN;
   localparam int CCW = $clog2(CYC);
   localparam int PHW = $clog2(STAGE_LEN);
   typedef logic [CCW-1:0] cc_t;
   typedef logic [PHW-1:0] ph_t;

   localparam cc_t CC_LAST  = cc_t'(CYC - 1);
   localparam cc_t CC_THR_A = cc_t'(STAGE_LEN - 1);
   localparam cc_t CC_TWO   = cc_t'(5 * STAGE_LEN - 1);
   localparam cc_t CC_THR_B = cc_t'(6 * STAGE_LEN - 1);
   localparam cc_t CC_E0    = cc_t'(2 * STAGE_LEN);
   localparam cc_t CC_E1    = cc_t'(3 * STAGE_LEN);
   localparam cc_t CC_E2    = cc_t'(7 * STAGE_LEN);
   localparam cc_t CC_E3    = cc_t'(8 * STAGE_LEN);
   localparam ph_t PH_LAST  = ph_t'(STAGE_LEN - 1);
   localparam ph_t PH_FIN   = ph_t'(STAGE_LEN - 2);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

   state_t           state, state_nxt;
   cc_t              cc;
   ph_t              ph;
   logic             run_pulse, fin_pulse, stop_lat, pause_i;
   logic             start_go, launch, seq_end, last_cycle;
   logic [RUN_W-1:0] target;
   logic [4:0]       ec, k, sc;
   logic [16:0]      recip_lut [32];

`ifdef NODE_SEQ_PAUSE_EN
   assign pause_i = pause;
`else
   assign pause_i = 1'b0;
`endif

   assign last_cycle = (run_cnt + RUN_W'(2)) == target;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (run_write && run_times != '0) state_nxt = S_RUN;
         S_RUN: begin
            if (cycle_finish) begin
               if (last_cycle || stop_lat) state_nxt = S_IDLE;
               else if (pause_i)           state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (stop_lat)      state_nxt = S_IDLE;
            else if (!pause_i) state_nxt = S_RUN;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      running  = (state != S_IDLE);
      start_go = (state == S_IDLE) && run_write && (run_times != '0);
      seq_end  = running && (state_nxt == S_IDLE);
      launch   = (state_nxt == S_RUN) &&
                 (((state == S_RUN) && cycle_finish) || (state == S_HOLD));
   end

   assign cycle_finish = (cc == CC_LAST);
   assign done         = fin_pulse;
   assign opt_run      = run_pulse || ((ph == '0) && (cc != '0)) || fin_pulse;
   assign exp_init     = (cc == CC_E0) || (cc == CC_E1) || (cc == CC_E2) || (cc == CC_E3);
   assign exp_fin      = (ph == PH_FIN);

   // ph tracks cc modulo STAGE_LEN so no divider is needed for the phase tests
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cc        <= '0;
         ph        <= '0;
         run_pulse <= 1'b0;
         fin_pulse <= 1'b0;
         target    <= '0;
         run_cnt   <= '0;
         stop_lat  <= 1'b0;
         opt_com   <= THR;
      end else begin
         run_pulse <= start_go || launch;
         fin_pulse <= seq_end;
         if (run_pulse) begin
            cc <= cc_t'(1);
            ph <= ph_t'(1);
         end else if (cycle_finish) begin
            cc <= '0;
            ph <= '0;
         end else if (cc != '0) begin
            cc <= cc + cc_t'(1);
            ph <= (ph == PH_LAST) ? '0 : ph + ph_t'(1);
         end
         if (start_go) begin
            target  <= RUN_W'(run_times * RUN_W'(BASE_NUM));
            run_cnt <= '0;
         end else if ((state == S_RUN) && cycle_finish) begin
            run_cnt <= run_cnt + RUN_W'(2);
         end
         if (start_go || seq_end)  stop_lat <= 1'b0;
         else if (running && stop) stop_lat <= 1'b1;
         if ((cc == CC_THR_A) || (cc == CC_THR_B))                   opt_com <= THR;
         else if (cc == CC_TWO)                                      opt_com <= TWO;
         else if (seq_end)                                           opt_com <= THR;
         else if (start_go || ((state == S_RUN) && cycle_finish))    opt_com <= OR1;
      end
   end

   for (genvar i = 0; i < 32; i++) begin : g_recip
      if (i == 0) begin : g_k0
         assign recip_lut[i] = 17'(32768 / EXP_TERMS);
      end else begin : g_kn
         assign recip_lut[i] = 17'(32768 / i);
      end
   end

   // ec==0 only occurs on the init clock; it shares the k=0 slot so the first value is 2^15/EXP_TERMS
   assign k = (ec == '0) ? '0 : ec - 5'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ec        <= '0;
         exp_run   <= 1'b0;
         exp_recip <= '0;
      end else begin
         if (exp_init) begin
            ec      <= 5'(EXP_TERMS);
            exp_run <= 1'b1;
         end else if (ec >= 5'd2) begin
            ec      <= ec - 5'd1;
            exp_run <= 1'b1;
         end else begin
            ec      <= '0;
            exp_run <= 1'b0;
         end
         if (exp_init || exp_run) exp_recip <= recip_lut[k];
      end
   end

   function automatic distance_command_t or_step(input logic [4:0] s);
      case (s)
         5'd0:    or_step = '{KN, ZERO};
         5'd1:    or_step = '{KM, MNS};
         5'd2:    or_step = '{KP, PLS};
         5'd3:    or_step = '{KN, MNS};
         5'd4:    or_step = '{LN, PLS};
         5'd5:    or_step = '{LP, MNS};
         5'd6:    or_step = '{KN, PLS};
         default: or_step = '{KN, DNOP};
      endcase
   endfunction

   function automatic distance_command_t tw_step(input logic [4:0] s);
      case (s)
         5'd0:    tw_step = '{KN, ZERO};
         5'd1:    tw_step = '{KM, MNS};
         5'd2:    tw_step = '{LM, PLS};
         5'd3:    tw_step = '{LN, MNS};
         5'd4:    tw_step = '{KN, PLS};
         default: tw_step = '{KN, DNOP};
      endcase
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sc              <= '0;
         or_distance_com <= '{KN, DNOP};
         tw_distance_com <= '{KN, DNOP};
      end else begin
         sc              <= opt_run ? '0 : ((sc == 5'd31) ? sc : sc + 5'd1);
         or_distance_com <= or_step(sc);
         tw_distance_com <= tw_step(sc);
      end
   end

endmodule
